// File: rtl/detect_window_ctrl.sv
// detect_window_ctrl
// Windowed serial pattern detector. A start request latches a pattern and a
// window length. The block then consumes exactly win_len valid bits and counts
// pattern occurrences among them. A one-cycle done pulse ends the window.
// Optional build macro: DETECT_NONOVERLAP_EN. When it is defined, a match
// empties the fill counter, so consecutive matches cannot share bits.
module detect_window_ctrl #(
    parameter int PAT_W = 4,
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [WIN_W-1:0] win_len,
    input  logic             x_valid,
    input  logic             x,
    output logic             busy,
    output logic             match,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             ovf
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [PAT_W-1:0]  sr_reg, sr_next, sr_shift;
    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [FILL_W-1:0] fill_reg, fill_next, fill_inc;
    logic [WIN_W-1:0]  len_reg, len_next;
    logic [WIN_W-1:0]  bit_reg, bit_next, bit_inc;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              ovf_reg, ovf_next;
    logic              match_reg, match_next;
    logic              done_reg, done_next;
    logic              busy_reg, busy_next;
    logic              hit;

    // Shift register candidate: the new bit enters at the LSB, so the oldest
    // bit moves toward the MSB.
    assign sr_shift[0] = x;
    generate
        for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
            assign sr_shift[gi] = sr_reg[gi-1];
        end
    endgenerate

    // Fill saturates at PAT_W, so a full register stays eligible for the
    // overlapping matches that follow.
    assign fill_inc = (fill_reg == FILL_FULL) ? FILL_FULL : fill_reg + 1'b1;
    assign bit_inc  = bit_reg + 1'b1;
    assign hit      = (fill_inc == FILL_FULL) && (sr_shift == pat_reg);

    // Next-state and datapath decode; abort outranks the bit and the window end.
    always_comb begin
        state_next = state_reg;
        sr_next    = sr_reg;
        pat_next   = pat_reg;
        fill_next  = fill_reg;
        len_next   = len_reg;
        bit_next   = bit_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        match_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pat_next   = pattern;
                    len_next   = win_len;
                    sr_next    = '0;
                    fill_next  = '0;
                    bit_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                    state_next = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (x_valid) begin
                    sr_next   = sr_shift;
                    fill_next = fill_inc;
                    bit_next  = bit_inc;
                    if (hit) begin
                        match_next = 1'b1;
                        if (cnt_reg == CNT_MAX) begin
                            ovf_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
`ifdef DETECT_NONOVERLAP_EN
                        fill_next = '0;
`endif
                    end
                    if (bit_inc == len_reg) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sr_reg    <= '0;
            pat_reg   <= '0;
            fill_reg  <= '0;
            len_reg   <= '0;
            bit_reg   <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
            match_reg <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sr_reg    <= sr_next;
            pat_reg   <= pat_next;
            fill_reg  <= fill_next;
            len_reg   <= len_next;
            bit_reg   <= bit_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
            match_reg <= match_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
        end
    end

    assign busy      = busy_reg;
    assign match     = match_reg;
    assign done      = done_reg;
    assign match_cnt = cnt_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_detect_window_ctrl.sv
// Testbench for detect_window_ctrl. Two instances share one stimulus stream:
// one uses the default counter width, and one uses a 2-bit counter that
// exercises saturation. Expected matches come from a positional scan of each
// window's bit list.
module tb_detect_window_ctrl;

    localparam int PAT_W = 4;
    localparam int WIN_W = 8;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;
    localparam int MAX_D = (1 << CNT_W) - 1;
    localparam int MAX_S = (1 << SAT_W) - 1;

`ifdef DETECT_NONOVERLAP_EN
    localparam bit NONOVL = 1'b1;
`else
    localparam bit NONOVL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [WIN_W-1:0] win_len;
    logic             x_valid;
    logic             x;
    logic             busy, match, done, ovf;
    logic [CNT_W-1:0] match_cnt;
    logic             s_busy, s_match, s_done, s_ovf;
    logic [SAT_W-1:0] s_match_cnt;

    int checks   = 0;
    int failures = 0;

    bit win_bits [256];
    bit exp_hit  [256];

    always #5 clk = ~clk;

    detect_window_ctrl #(.PAT_W(PAT_W), .WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .win_len(win_len), .x_valid(x_valid), .x(x),
        .busy(busy), .match(match), .done(done), .match_cnt(match_cnt), .ovf(ovf)
    );

    detect_window_ctrl #(.PAT_W(PAT_W), .WIN_W(WIN_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .pattern(pattern), .win_len(win_len), .x_valid(x_valid), .x(x),
        .busy(s_busy), .match(s_match), .done(s_done), .match_cnt(s_match_cnt), .ovf(s_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Marks window position i as a match when the PAT_W bits ending there,
    // oldest first, spell the pattern. Non-overlapping mode also requires the
    // candidate to start after the previous match.
    function automatic void build_expect(input logic [PAT_W-1:0] p, input int len);
        int last_end;
        bit ok;
        last_end = -1;
        for (int i = 0; i < len; i++) begin
            exp_hit[i] = 1'b0;
            if (i >= PAT_W - 1 && (!NONOVL || (i - PAT_W + 1) > last_end)) begin
                ok = 1'b1;
                for (int k = 0; k < PAT_W; k++)
                    if (win_bits[i-PAT_W+1+k] != p[PAT_W-1-k]) ok = 1'b0;
                if (ok) begin
                    exp_hit[i] = 1'b1;
                    last_end   = i;
                end
            end
        end
    endfunction

    // One full window: start, len bits with random idle gaps, done, back to idle.
    task automatic run_window(input string tag, input logic [PAT_W-1:0] p, input int len,
                              input int min_gap, input int max_gap, input bit poke_start);
        int cum;
        int gap;
        int e_cnt, e_scnt;
        cum = 0;
        build_expect(p, len);
        pattern = p;
        win_len = len[WIN_W-1:0];
        start   = 1'b1;
        step();
        start   = 1'b0;
        pattern = PAT_W'($urandom);
        win_len = WIN_W'($urandom);
        checks++;
        if ({busy, done, match} !== {len != 0, len == 0, 1'b0}) begin
            failures++;
            $display("FAIL %s start_flags busy/done/match=%b required=%b", tag,
                     {busy, done, match}, {len != 0, len == 0, 1'b0});
        end
        checks++;
        if ({match_cnt, ovf, s_match_cnt, s_ovf} !== '0) begin
            failures++;
            $display("FAIL %s start_clear cnt=%0d ovf=%0b scnt=%0d sovf=%0b required all 0",
                     tag, match_cnt, ovf, s_match_cnt, s_ovf);
        end
        for (int i = 0; i < len; i++) begin
            gap = $urandom_range(max_gap, min_gap);
            if (i == 0 && !poke_start) gap = 0;
            for (int g = 0; g < gap; g++) begin
                x_valid = 1'b0;
                x       = 1'($urandom);
                start   = poke_start;
                step();
                start   = 1'b0;
                checks++;
                if ({busy, match, done} !== 3'b100) begin
                    failures++;
                    $display("FAIL %s gap_flags bit=%0d busy/match/done=%b required=100",
                             tag, i, {busy, match, done});
                end
            end
            x_valid = 1'b1;
            x       = win_bits[i];
            step();
            x_valid = 1'b0;
            if (exp_hit[i]) cum++;
            e_cnt  = (cum > MAX_D) ? MAX_D : cum;
            e_scnt = (cum > MAX_S) ? MAX_S : cum;
            checks++;
            if ({busy, match, done} !== {i != len - 1, exp_hit[i], i == len - 1}) begin
                failures++;
                $display("FAIL %s bit_flags bit=%0d busy/match/done=%b required=%b", tag, i,
                         {busy, match, done}, {i != len - 1, exp_hit[i], i == len - 1});
            end
            checks++;
            if (match_cnt !== CNT_W'(e_cnt) || ovf !== (cum > MAX_D)) begin
                failures++;
                $display("FAIL %s count bit=%0d cnt=%0d ovf=%0b required cnt=%0d ovf=%0b",
                         tag, i, match_cnt, ovf, e_cnt, cum > MAX_D);
            end
            checks++;
            if (s_match_cnt !== SAT_W'(e_scnt) || s_ovf !== (cum > MAX_S) || s_match !== exp_hit[i]) begin
                failures++;
                $display("FAIL %s sat_count bit=%0d cnt=%0d ovf=%0b match=%0b required cnt=%0d ovf=%0b match=%0b",
                         tag, i, s_match_cnt, s_ovf, s_match, e_scnt, cum > MAX_S, exp_hit[i]);
            end
        end
        step();
        e_cnt = (cum > MAX_D) ? MAX_D : cum;
        checks++;
        if ({busy, match, done} !== 3'b000 || match_cnt !== CNT_W'(e_cnt)) begin
            failures++;
            $display("FAIL %s after_done busy/match/done=%b cnt=%0d required 000 cnt=%0d",
                     tag, {busy, match, done}, match_cnt, e_cnt);
        end
        $display("window %s pat=%b len=%0d matches=%0d cnt=%0d ovf=%0b scnt=%0d sovf=%0b",
                 tag, p, len, cum, match_cnt, ovf, s_match_cnt, s_ovf);
    endtask

    task automatic load_bits(input logic [15:0] v, input int n);
        for (int i = 0; i < n; i++) win_bits[i] = v[n-1-i];
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({busy, match, done, ovf, match_cnt, s_busy, s_match, s_done, s_ovf, s_match_cnt} !== '0) begin
            failures++;
            $display("FAIL reset outputs busy=%0b match=%0b done=%0b cnt=%0d ovf=%0b required all 0",
                     busy, match, done, match_cnt, ovf);
        end
        rst = 1'b0;
        step();
        $display("reset released");
    endtask

    task automatic test_overlap();
        load_bits(16'b1011_0110, 8);
        run_window("overlap", 4'b1011, 8, 0, 0, 1'b0);
        checks++;
        if (match_cnt !== (NONOVL ? 8'd1 : 8'd2)) begin
            failures++;
            $display("FAIL overlap_total cnt=%0d required=%0d", match_cnt, NONOVL ? 1 : 2);
        end
    endtask

    task automatic test_saturation();
        load_bits(16'h03ff, 10);
        run_window("saturation", 4'b1111, 10, 0, 0, 1'b0);
        checks++;
        if (s_match_cnt !== (NONOVL ? 2'd2 : 2'd3) || s_ovf !== !NONOVL) begin
            failures++;
            $display("FAIL saturation_total cnt=%0d ovf=%0b required cnt=%0d ovf=%0b",
                     s_match_cnt, s_ovf, NONOVL ? 2 : 3, !NONOVL);
        end
    endtask

    task automatic test_gaps();
        load_bits(16'b0110, 4);
        run_window("gaps", 4'b0110, 4, 3, 3, 1'b1);
        checks++;
        if (match_cnt !== 8'd1) begin
            failures++;
            $display("FAIL gaps_total cnt=%0d required=1", match_cnt);
        end
    endtask

    task automatic test_zero_len();
        run_window("zero_len", 4'($urandom), 0, 0, 0, 1'b0);
    endtask

    task automatic test_abort();
        logic [PAT_W-1:0] p;
        p = 4'($urandom);
        pattern = p;
        win_len = 8'd8;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x_valid = 1'b1;
            x       = p[PAT_W-1-i];
            abort   = (i == 3);
            step();
        end
        x_valid = 1'b0;
        abort   = 1'b0;
        checks++;
        if ({busy, match, done} !== 3'b000 || match_cnt !== 8'd0) begin
            failures++;
            $display("FAIL abort_exit busy/match/done=%b cnt=%0d required 000 cnt=0",
                     {busy, match, done}, match_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            x_valid = 1'b1;
            x       = 1'($urandom);
            step();
            checks++;
            if ({busy, match, done} !== 3'b000) begin
                failures++;
                $display("FAIL abort_idle cycle=%0d busy/match/done=%b required=000", i, {busy, match, done});
            end
        end
        x_valid = 1'b0;
        $display("abort pat=%b after 3 bits cnt=%0d", p, match_cnt);
        for (int i = 0; i < 8; i++) win_bits[i] = 1'($urandom);
        run_window("after_abort", 4'($urandom), 8, 0, 1, 1'b0);
    endtask

    task automatic test_rst_mid_run();
        pattern = 4'b1011;
        win_len = 8'd20;
        start   = 1'b1;
        step();
        start   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x_valid = 1'b1;
            x       = (i == 1) ? 1'b0 : 1'b1;
            step();
        end
        checks++;
        if (match_cnt !== 8'd1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre cnt=%0d busy=%0b required cnt=1 busy=1", match_cnt, busy);
        end
        x   = 1'b1;
        rst = 1'b1;
        step();
        rst     = 1'b0;
        x_valid = 1'b0;
        checks++;
        if ({busy, match, done, ovf, match_cnt, s_busy, s_match, s_done, s_ovf, s_match_cnt} !== '0) begin
            failures++;
            $display("FAIL rst_mid outputs busy=%0b match=%0b done=%0b cnt=%0d ovf=%0b required all 0",
                     busy, match, done, match_cnt, ovf);
        end
        step();
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL rst_idle busy/done=%b required=00", {busy, done});
        end
        $display("reset mid-run cleared cnt=%0d", match_cnt);
    endtask

    task automatic test_random();
        int len;
        logic [PAT_W-1:0] p;
        for (int w = 0; w < 20; w++) begin
            p   = 4'($urandom);
            len = $urandom_range(60, 1);
            for (int i = 0; i < len; i++)
                win_bits[i] = ($urandom_range(3, 0) == 0) ? 1'($urandom) : p[PAT_W-1-(i % PAT_W)];
            run_window("random", p, len, 0, 2, 1'b0);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        pattern = '0;
        win_len = '0;
        x_valid = 1'b0;
        x       = 1'b0;
        test_reset();
        test_overlap();
        test_saturation();
        test_gaps();
        test_zero_len();
        test_abort();
        test_rst_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
